mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit in the execute stage, alongside the ALU. It executes MULT/MULTU/DIV/DIVU into private HI/LO registers and services MTHI/MTLO writes. HI/LO are read by MFHI/MFLO. The hazard logic stalls fetch/decode while `busy_o` is high.

---
 rtl/mult_div_unit.sv | 187 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle,
// committing into private HI/LO registers; also services MTHI/MTLO writes while idle.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] rs_i,
   input  logic [WIDTH-1:0] rt_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned ACC_W = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_is_div;
   logic             r_neg_res;
   logic             r_neg_rem;
   logic             r_div0;
   logic [WIDTH-1:0] r_opb;
   logic [ACC_W-1:0] r_acc;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_busy;
   logic             r_done;

   logic             w_launch;
   logic             w_step;
   logic             w_commit;
   logic             w_idle_wr;
   logic             w_last;

   logic             w_rs_neg;
   logic             w_rt_neg;
   logic [WIDTH-1:0] w_rs_mag;
   logic [WIDTH-1:0] w_rt_mag;

   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_sh;
   logic [WIDTH:0]   w_div_diff;
   logic [ACC_W-1:0] w_acc_nxt;

   logic [ACC_W-1:0] w_prod;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_rem;
   logic [WIDTH-1:0] w_hi_res;
   logic [WIDTH-1:0] w_lo_res;

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; flush returns to idle from any active state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (start_i && !flush_i) w_state_nxt = S_RUN;
         S_RUN: begin
            if (flush_i)     w_state_nxt = S_IDLE;
            else if (w_last) w_state_nxt = S_FIN;
         end
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Control strobes decoded from the current state
   always_comb begin
      w_launch  = 1'b0;
      w_step    = 1'b0;
      w_commit  = 1'b0;
      w_idle_wr = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_launch  = start_i && !flush_i;
            w_idle_wr = 1'b1;
         end
         S_RUN:   w_step   = !flush_i;
         S_FIN:   w_commit = !flush_i;
         default: ;
      endcase
   end

   // Operand magnitudes for signed ops
   assign w_rs_neg = op_i[0] && rs_i[WIDTH-1];
   assign w_rt_neg = op_i[0] && rt_i[WIDTH-1];
   assign w_rs_mag = w_rs_neg ? (~rs_i + WIDTH'(1)) : rs_i;
   assign w_rt_mag = w_rt_neg ? (~rt_i + WIDTH'(1)) : rt_i;

   // One iteration: multiply adds into the upper half then shifts right;
   // divide shifts the partial remainder left and keeps the trial subtraction if it fits.
   assign w_mul_sum  = {1'b0, r_acc[ACC_W-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
   assign w_div_sh   = r_acc[ACC_W-1:WIDTH-1];
   assign w_div_diff = w_div_sh - {1'b0, r_opb};

   always_comb begin
      w_acc_nxt = r_acc;
      if (!r_is_div) begin
         w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
      end else if (!w_div_diff[WIDTH]) begin
         w_acc_nxt = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
         w_acc_nxt = {w_div_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
   end

   // Sign correction; a zero divisor yields an all-ones quotient, and the
   // remainder path already reproduces the original dividend in that case.
   assign w_prod   = r_neg_res ? (~r_acc + ACC_W'(1)) : r_acc;
   assign w_quot   = r_div0 ? '1 :
                     (r_neg_res ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0]);
   assign w_rem    = r_neg_rem ? (~r_acc[ACC_W-1:WIDTH] + WIDTH'(1)) : r_acc[ACC_W-1:WIDTH];
   assign w_hi_res = r_is_div ? w_rem  : w_prod[ACC_W-1:WIDTH];
   assign w_lo_res = r_is_div ? w_quot : w_prod[WIDTH-1:0];

   // Datapath and architected registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_div0    <= 1'b0;
         r_opb     <= '0;
         r_acc     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         if (w_launch) begin
            r_cnt     <= '0;
            r_is_div  <= op_i[1];
            r_neg_res <= w_rs_neg ^ w_rt_neg;
            r_neg_rem <= op_i[1] && w_rs_neg;
            r_div0    <= op_i[1] && (rt_i == '0);
            r_opb     <= op_i[1] ? w_rt_mag : w_rs_mag;
            r_acc     <= {WIDTH'(0), (op_i[1] ? w_rs_mag : w_rt_mag)};
         end else if (w_step) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= w_acc_nxt;
         end

         if (w_commit) begin
            r_hi <= w_hi_res;
            r_lo <= w_lo_res;
         end else if (w_idle_wr) begin
            if (hi_we_i) r_hi <= wdata_i;
            if (lo_we_i) r_lo <= wdata_i;
         end

         r_busy <= (w_state_nxt != S_IDLE);
         r_done <= w_commit;
      end
   end

   assign busy_o = r_busy;
   assign done_o = r_done;
   assign hi_o   = r_hi;
   assign lo_o   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] rs_i;
   logic [31:0] rt_i;
   logic        hi_we_i;
   logic        lo_we_i;
   logic [31:0] wdata_i;
   logic        flush_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .op_i    (op_i),
      .rs_i    (rs_i),
      .rt_i    (rt_i),
      .hi_we_i (hi_we_i),
      .lo_we_i (lo_we_i),
      .wdata_i (wdata_i),
      .flush_i (flush_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .hi_o    (hi_o),
      .lo_o    (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Reference: {HI, LO} from the architectural definition of each op
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p;
      int     ia, ib, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ia = $signed(a);
      ib = $signed(b);
      case (op)
         2'b00: res = {32'd0, a} * {32'd0, b};
         2'b01: begin p = sa * sb; res = 64'(p); end
         2'b10: res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
            else begin q = ia / ib; r = ia % ib; res = {32'(r), 32'(q)}; end
         end
      endcase
      return res;
   endfunction

   // Issue one op at the current negedge and wait (bounded) for busy to drop
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cyc, output logic first_busy, output logic overlap);
      start_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
      @(negedge clk);
      start_i = 1'b0;
      first_busy = busy_o;
      busy_cyc = 0;
      overlap = 1'b0;
      while (busy_o && busy_cyc < 100) begin
         if (done_o) overlap = 1'b1;
         busy_cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; start_i = 1'b0; op_i = 2'b00; rs_i = '0; rt_i = '0;
      hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0; flush_i = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (hi_o !== 32'd0)  begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi_o); end
      n_checks++; if (lo_o !== 32'd0)  begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
      rst = 1'b1;
      @(negedge clk);
      exp_hi = '0; exp_lo = '0;
   endtask

   task automatic test_multu_max;
      int cyc; logic fb, ov;
      do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, fb, ov);
      n_checks++; if (cyc != 33)  begin n_fail++; $display("FAIL multu_busy_len: got %0d want 33", cyc); end
      n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL multu_done_during_busy: got %b want 0", ov); end
      n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL multu_done: got %b want 1", done_o); end
      n_checks++; if (hi_o !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi_o); end
      n_checks++; if (lo_o !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", lo_o); end
      @(negedge clk);
      n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b want 0", done_o); end
      exp_hi = 32'hFFFF_FFFE; exp_lo = 32'h1;
   endtask

   task automatic test_signs;
      int cyc; logic fb, ov;
      do_op(2'b01, 32'hFFFF_FFFD, 32'd5, cyc, fb, ov);
      n_checks++; if (hi_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi_o); end
      n_checks++; if (lo_o !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_neg_lo: got %h want fffffff1", lo_o); end
      do_op(2'b11, 32'hFFFF_FFF9, 32'd2, cyc, fb, ov);
      n_checks++; if (lo_o !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h want fffffffd", lo_o); end
      n_checks++; if (hi_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h want ffffffff", hi_o); end
      do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, cyc, fb, ov);
      n_checks++; if (lo_o !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h want 80000000", lo_o); end
      n_checks++; if (hi_o !== 32'd0) begin n_fail++; $display("FAIL div_ovf_hi: got %h want 0", hi_o); end
      exp_hi = 32'd0; exp_lo = 32'h8000_0000;
   endtask

   task automatic test_div_zero;
      int cyc; logic fb, ov;
      do_op(2'b10, 32'd100, 32'd0, cyc, fb, ov);
      n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL divz_busy_len: got %0d want 33", cyc); end
      n_checks++; if (lo_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_lo: got %h want ffffffff", lo_o); end
      n_checks++; if (hi_o !== 32'd100) begin n_fail++; $display("FAIL divz_hi: got %h want 00000064", hi_o); end
      do_op(2'b11, 32'hFFFF_FFFB, 32'd0, cyc, fb, ov);
      n_checks++; if (lo_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_s_lo: got %h want ffffffff", lo_o); end
      n_checks++; if (hi_o !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL divz_s_hi: got %h want fffffffb", hi_o); end
      exp_hi = 32'hFFFF_FFFB; exp_lo = 32'hFFFF_FFFF;
   endtask

   task automatic test_busy_ignore;
      int cyc;
      @(negedge clk);
      hi_we_i = 1'b1; wdata_i = 32'h1234;
      @(negedge clk);
      hi_we_i = 1'b0;
      exp_hi = 32'h1234;
      n_checks++; if (hi_o !== 32'h1234) begin n_fail++; $display("FAIL mthi: got %h want 00001234", hi_o); end
      start_i = 1'b1; op_i = 2'b00; rs_i = 32'd6; rt_i = 32'd7;
      @(negedge clk);
      start_i = 1'b0;
      cyc = 0;
      while (busy_o && cyc < 100) begin
         cyc++;
         if (cyc == 5) begin
            start_i = 1'b1; op_i = 2'b11; rs_i = 32'd99; rt_i = 32'd7;
            lo_we_i = 1'b1; wdata_i = 32'hDEAD;
         end else begin
            start_i = 1'b0; lo_we_i = 1'b0;
         end
         if (cyc == 10) begin
            n_checks++; if (hi_o !== exp_hi) begin n_fail++; $display("FAIL busy_hi_hold: got %h want %h", hi_o, exp_hi); end
            n_checks++; if (lo_o !== exp_lo) begin n_fail++; $display("FAIL busy_lo_hold: got %h want %h", lo_o, exp_lo); end
         end
         @(negedge clk);
      end
      start_i = 1'b0; lo_we_i = 1'b0;
      n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL ign_busy_len: got %0d want 33", cyc); end
      n_checks++; if (hi_o !== 32'd0)  begin n_fail++; $display("FAIL ign_hi: got %h want 0", hi_o); end
      n_checks++; if (lo_o !== 32'd42) begin n_fail++; $display("FAIL ign_lo: got %h want 0000002a", lo_o); end
      repeat (3) @(negedge clk);
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ign_no_queue: got %b want 0", busy_o); end
      exp_hi = 32'd0; exp_lo = 32'd42;
   endtask

   task automatic test_flush;
      logic saw;
      start_i = 1'b1; op_i = 2'b10; rs_i = 32'd1000; rt_i = 32'd3;
      @(negedge clk);
      start_i = 1'b0;
      repeat (9) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy_o); end
      n_checks++; if (hi_o !== exp_hi) begin n_fail++; $display("FAIL flush_hi: got %h want %h", hi_o, exp_hi); end
      n_checks++; if (lo_o !== exp_lo) begin n_fail++; $display("FAIL flush_lo: got %h want %h", lo_o, exp_lo); end
      saw = 1'b0;
      repeat (40) begin @(negedge clk); if (done_o) saw = 1'b1; end
      n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b want 0", saw); end
      start_i = 1'b1; flush_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h55;
      op_i = 2'b00; rs_i = 32'd6; rt_i = 32'd7;
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0; lo_we_i = 1'b0;
      exp_lo = 32'h55;
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b want 0", busy_o); end
      n_checks++; if (lo_o !== 32'h55) begin n_fail++; $display("FAIL flush_start_mtlo: got %h want 00000055", lo_o); end
      saw = 1'b0;
      repeat (40) begin @(negedge clk); if (done_o || busy_o) saw = 1'b1; end
      n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL flush_start_idle: got %b want 0", saw); end
      n_checks++; if (hi_o !== exp_hi) begin n_fail++; $display("FAIL flush_start_hi: got %h want %h", hi_o, exp_hi); end
   endtask

   task automatic test_reset_mid_op;
      int cyc; logic fb, ov;
      start_i = 1'b1; op_i = 2'b01; rs_i = 32'd12345; rt_i = 32'hFFFF_FFF9;
      @(negedge clk);
      start_i = 1'b0;
      repeat (14) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
      n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done_o); end
      n_checks++; if (hi_o !== 32'd0) begin n_fail++; $display("FAIL rstmid_hi: got %h want 0", hi_o); end
      n_checks++; if (lo_o !== 32'd0) begin n_fail++; $display("FAIL rstmid_lo: got %h want 0", lo_o); end
      @(negedge clk);
      rst = 1'b1;
      do_op(2'b00, 32'd2, 32'd3, cyc, fb, ov);
      n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL rstmid_new_len: got %0d want 33", cyc); end
      n_checks++; if (lo_o !== 32'd6) begin n_fail++; $display("FAIL rstmid_new_lo: got %h want 00000006", lo_o); end
      n_checks++; if (hi_o !== 32'd0) begin n_fail++; $display("FAIL rstmid_new_hi: got %h want 0", hi_o); end
      exp_hi = 32'd0; exp_lo = 32'd6;
   endtask

   task automatic test_back_to_back;
      int cyc; logic fb, ov;
      do_op(2'b00, 32'd10, 32'd20, cyc, fb, ov);
      n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b want 1", done_o); end
      do_op(2'b10, 32'd17, 32'd5, cyc, fb, ov);
      n_checks++; if (fb !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accepted: got %b want 1", fb); end
      n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL b2b_second_len: got %0d want 33", cyc); end
      n_checks++; if (lo_o !== 32'd3) begin n_fail++; $display("FAIL b2b_lo: got %h want 00000003", lo_o); end
      n_checks++; if (hi_o !== 32'd2) begin n_fail++; $display("FAIL b2b_hi: got %h want 00000002", hi_o); end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic test_random;
      int cyc; logic fb, ov;
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [63:0] ref_v;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = pick();
         b  = pick();
         ref_v = model(op, a, b);
         do_op(op, a, b, cyc, fb, ov);
         n_checks++; if (cyc != 33 || done_o !== 1'b1) begin n_fail++; $display("FAIL rnd_timing[%0d]: got len %0d done %b want 33/1", i, cyc, done_o); end
         n_checks++; if (hi_o !== ref_v[63:32]) begin n_fail++; $display("FAIL rnd_hi[%0d] op%0d %h,%h: got %h want %h", i, op, a, b, hi_o, ref_v[63:32]); end
         n_checks++; if (lo_o !== ref_v[31:0]) begin n_fail++; $display("FAIL rnd_lo[%0d] op%0d %h,%h: got %h want %h", i, op, a, b, lo_o, ref_v[31:0]); end
      end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_signs();
      test_div_zero();
      test_busy_ignore();
      test_flush();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
